// File: rtl/dict_index_unpacker.sv
// dict_index_unpacker: unpacks packed codebook-index words into one index per cycle,
// with zero-bubble word chaining and sticky flagging of illegal index counts.
module dict_index_unpacker #(
  parameter int INDEX_BITS       = 3,
  parameter int INDICES_PER_WORD = 8,
  parameter int WORD_WIDTH       = INDEX_BITS * INDICES_PER_WORD,
  parameter int CNT_BITS         = $clog2(INDICES_PER_WORD + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_word,
  input  logic [CNT_BITS-1:0]   in_count,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INDEX_BITS-1:0] out_index,
  output logic                  out_last,
  output logic                  err_sticky
);
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(INDICES_PER_WORD);
  state_t                r_state, w_next;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [CNT_BITS-1:0]   r_rem, w_eff;
  logic                  r_last, w_final, w_hs, w_acc, w_bad;
  always_comb begin
    w_final   = r_rem == CNT_BITS'(1);
    out_valid = r_state == EMIT;
    w_hs      = out_valid & out_ready;
    // Final index handshake frees the slot, so the next word loads on the same edge.
    in_ready  = rst_n & ((r_state == IDLE) | (w_hs & w_final));
    w_acc     = in_valid & in_ready;
    w_bad     = (in_count == '0) | (in_count > MAX_CNT);
    w_eff     = (in_count > MAX_CNT) ? MAX_CNT : in_count;
    out_index = r_shift[INDEX_BITS-1:0];
    out_last  = out_valid & r_last & w_final;
    w_next    = w_acc ? ((in_count == '0) ? IDLE : EMIT)
              : ((w_hs & w_final) ? IDLE : r_state);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_rem      <= '0;
      r_last     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (w_acc) begin
        r_shift <= in_word;
        r_rem   <= w_eff;
        r_last  <= in_last;
      end else if (w_hs & !w_final) begin
        r_shift <= r_shift >> INDEX_BITS;
        r_rem   <= r_rem - CNT_BITS'(1);
      end
      if (w_acc & w_bad) err_sticky <= 1'b1;
    end
  end
endmodule
